// File: rtl/smart_home_pkg.sv
// rtl/smart_home_pkg.sv - shared state codes and default thermal thresholds
package smart_home_pkg;

    // State encoding doubles as the 3-bit display code
    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_FDOOR = 3'b001,
        ST_RDOOR = 3'b010,
        ST_WIN   = 3'b011,
        ST_FIRE  = 3'b100,
        ST_HOLD  = 3'b101
    } state_t;

    localparam int DEF_HEAT_ON  = 50;
    localparam int DEF_HEAT_OFF = 55;
    localparam int DEF_COOL_ON  = 85;
    localparam int DEF_COOL_OFF = 80;

    // True while the fire alarm owns the house (thermal loads are shed)
    function automatic logic is_alarm(input state_t s);
        return (s == ST_FIRE) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - single-bit debouncer requiring DB_CYC consecutive mismatches
module sensor_debounce #(
    parameter int DB_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);

    localparam int CNT_W = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // Count consecutive disagreeing samples; adopt raw on the DB_CYC-th one
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (raw != filt) begin
            if (cnt == LAST) begin
                filt <= raw;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/smart_home_ctrl_p.sv
// rtl/smart_home_ctrl_p.sv - smart-home controller: debounce, priority FSM, alarm hold, thermal control
module smart_home_ctrl_p
    import smart_home_pkg::*;
#(
    parameter int TEMP_W     = 7,
    parameter int N_WIN      = 4,
    parameter int WIN_IW     = (N_WIN > 1) ? $clog2(N_WIN) : 1,
    parameter int DB_CYC     = 4,
    parameter int ALARM_HOLD = 16,
    parameter int HEAT_ON    = DEF_HEAT_ON,
    parameter int HEAT_OFF   = DEF_HEAT_OFF,
    parameter int COOL_ON    = DEF_COOL_ON,
    parameter int COOL_OFF   = DEF_COOL_OFF
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              SFD,
    input  logic              SRD,
    input  logic [N_WIN-1:0]  SW,
    input  logic              SFA,
    input  logic [TEMP_W-1:0] ST,
    output logic              fdoor,
    output logic              rdoor,
    output logic              winbuzz,
    output logic [WIN_IW-1:0] win_id,
    output logic              alarmbuzz,
    output logic              heater,
    output logic              cooler,
    output logic [2:0]        display
);

    localparam int HOLD_W = (ALARM_HOLD > 1) ? $clog2(ALARM_HOLD) : 1;

    localparam logic [TEMP_W-1:0] HEAT_ON_T  = TEMP_W'(HEAT_ON);
    localparam logic [TEMP_W-1:0] HEAT_OFF_T = TEMP_W'(HEAT_OFF);
    localparam logic [TEMP_W-1:0] COOL_ON_T  = TEMP_W'(COOL_ON);
    localparam logic [TEMP_W-1:0] COOL_OFF_T = TEMP_W'(COOL_OFF);

    logic             fd, rd, fa;
    logic [N_WIN-1:0] w;

    state_t            state, next_state, target;
    logic [HOLD_W-1:0] hold_cnt, next_hold;
    logic [WIN_IW-1:0] low_idx;
    logic              shed;

    sensor_debounce #(.DB_CYC(DB_CYC)) u_db_fd (.clk(clk), .rst(Rst), .raw(SFD), .filt(fd));
    sensor_debounce #(.DB_CYC(DB_CYC)) u_db_rd (.clk(clk), .rst(Rst), .raw(SRD), .filt(rd));
    sensor_debounce #(.DB_CYC(DB_CYC)) u_db_fa (.clk(clk), .rst(Rst), .raw(SFA), .filt(fa));

    for (genvar i = 0; i < N_WIN; i++) begin : g_win_db
        sensor_debounce #(.DB_CYC(DB_CYC)) u_db_w (.clk(clk), .rst(Rst), .raw(SW[i]), .filt(w[i]));
    end

    // Lowest-numbered open window wins the report
    always_comb begin
        low_idx = '0;
        for (int i = N_WIN - 1; i >= 0; i--) begin
            if (w[i]) low_idx = WIN_IW'(i);
        end
    end

    // Fixed-priority target plus fire/hold overrides
    always_comb begin
        if (fd)      target = ST_FDOOR;
        else if (rd) target = ST_RDOOR;
        else if (|w) target = ST_WIN;
        else         target = ST_IDLE;

        next_state = target;
        next_hold  = hold_cnt;
        if (fa) begin
            next_state = ST_FIRE;
        end else begin
            case (state)
                ST_IDLE, ST_FDOOR, ST_RDOOR, ST_WIN: next_state = target;
                ST_FIRE: begin
                    next_state = ST_HOLD;
                    next_hold  = HOLD_W'(ALARM_HOLD - 1);
                end
                ST_HOLD: begin
                    if (hold_cnt == '0) begin
                        next_state = target;
                    end else begin
                        next_state = ST_HOLD;
                        next_hold  = hold_cnt - HOLD_W'(1);
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // State register with outputs registered from the state being entered
    always_ff @(posedge clk) begin
        if (Rst) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            fdoor     <= 1'b0;
            rdoor     <= 1'b0;
            winbuzz   <= 1'b0;
            win_id    <= '0;
            alarmbuzz <= 1'b0;
            display   <= 3'b000;
        end else begin
            state     <= next_state;
            hold_cnt  <= next_hold;
            fdoor     <= (next_state == ST_FDOOR);
            rdoor     <= (next_state == ST_RDOOR);
            winbuzz   <= (next_state == ST_WIN);
            win_id    <= (next_state == ST_WIN) ? low_idx : '0;
            alarmbuzz <= is_alarm(next_state);
            display   <= next_state;
        end
    end

    // Loads stay off on the edge entering FIRE and the edge leaving HOLD
    assign shed = is_alarm(state) || is_alarm(next_state);

    // Hysteresis thermostat; between thresholds each output holds
    always_ff @(posedge clk) begin
        if (Rst || shed) begin
            heater <= 1'b0;
            cooler <= 1'b0;
        end else begin
            if (ST < HEAT_ON_T)        heater <= 1'b1;
            else if (ST >= HEAT_OFF_T) heater <= 1'b0;

            if (ST > COOL_ON_T)        cooler <= 1'b1;
            else if (ST <= COOL_OFF_T) cooler <= 1'b0;
        end
    end

endmodule

// File: doc/smart_home_ctrl_p.md
# smart_home_ctrl_p

Parametrised second-generation smart-home controller. It debounces the door, window and fire-alarm sensors and arbitrates them by fixed priority through a Moore state machine. It drives the door/buzzer indicators and a 3-bit state display, and runs heater/cooler control with programmable hysteresis. It replaces the fixed-width, single-window controller at the top of the home-control path.

## Interface
Parameters:
- TEMP_W, 7: temperature width (unsigned)
- N_WIN, 4: number of window sensors
- WIN_IW, $clog2(N_WIN) (min 1): width of win_id
- DB_CYC, 4: debounce length in cycles (≥1)
- ALARM_HOLD, 16: cycles alarmbuzz persists after SFA clears (≥1)
- HEAT_ON, 50 / HEAT_OFF, 55: heater turns on when ST < HEAT_ON, off when ST ≥ HEAT_OFF
- COOL_ON, 85 / COOL_OFF, 80: cooler turns on when ST > COOL_ON, off when ST ≤ COOL_OFF
- Legal ordering: HEAT_ON ≤ HEAT_OFF < COOL_OFF ≤ COOL_ON

Ports:
- clk  in  1  single clock, rising edge
- Rst  in  1  synchronous, active-high reset
- SFD  in  1  front-door sensor
- SRD  in  1  rear-door sensor
- SW  in  N_WIN  window sensors, 1 = open
- SFA  in  1  fire-alarm sensor
- ST  in  TEMP_W  temperature
- fdoor  out  1  front door indicator
- rdoor  out  1  rear door indicator
- winbuzz  out  1  window buzzer
- win_id  out  WIN_IW  index of the reported open window
- alarmbuzz  out  1  fire alarm buzzer
- heater  out  1  heater enable
- cooler  out  1  cooler enable
- display  out  3  current state code

## Operation
- **Debounce.** Each of SFD, SRD, SFA and SW[i] feeds its own debouncer.
  - The counter increments on each edge where raw ≠ filtered, and clears on any edge where raw = filtered.
  - On the DB_CYC-th consecutive mismatching edge, the filtered value takes the raw value and the counter clears.
  - Glitches shorter than DB_CYC cycles are ignored.
- **States (display code):** IDLE 000, FDOOR 001, RDOOR 010, WIN 011, FIRE 100, HOLD 101. Codes 110 and 111 are unused and go to IDLE on the next edge.
- **Transitions** use the filtered signals fa, fd, rd, w:
  - From any state, fa=1 → FIRE.
  - FIRE with fa=0 → HOLD; the hold counter loads ALARM_HOLD−1.
  - HOLD: fa=1 → FIRE. Otherwise the counter decrements, and at 0 the state goes to the priority target.
  - Priority target from IDLE/FDOOR/RDOOR/WIN: fd → FDOOR, else rd → RDOOR, else |w → WIN, else IDLE. It is re-evaluated every cycle, so a higher-priority event preempts immediately.
- **Outputs** are decoded from the registered state:
  - fdoor=1 only in FDOOR; rdoor=1 only in RDOOR; winbuzz=1 only in WIN.
  - alarmbuzz=1 in FIRE and HOLD.
  - display = state code.
- **win_id** is registered alongside the state. It holds the lowest index i with w[i]=1 while in WIN, and is 0 otherwise. It updates in WIN if the lowest open index changes.
- **Thermal control.** heater and cooler are registered and updated every edge from ST, using unsigned TEMP_W-bit compares with the set/clear thresholds above.
  - Between the thresholds, each holds its previous value.
  - In FIRE/HOLD both are forced 0. They resume evaluation from 0 on the first edge after leaving HOLD.
  - heater and cooler are never both 1.
- **Reset (Rst=1 at edge):** state IDLE and every output 0: fdoor, rdoor, winbuzz, win_id, alarmbuzz, heater, cooler, display. All filtered values and counters also go to 0. Reset mid-FIRE/HOLD drops alarmbuzz on the same edge.

## Timing
- Sensor latency: if raw rises before edge k and stays high, filtered rises at edge k+DB_CYC−1 and state/outputs change at edge k+DB_CYC. With the default DB_CYC=4 this is 4 edges after the first sampled edge.
- Simultaneous filtered events resolve by priority in the same edge: FIRE > FDOOR > RDOOR > WIN.
- After filtered fa falls, alarmbuzz stays high for exactly ALARM_HOLD cycles after FIRE is exited.
- Thermal latency: 1 edge from ST to heater/cooler.

## Structure
- Package smart_home_pkg holds:
  - state enum with explicit 3-bit codes (shared with the display decoder)
  - default threshold constants
- Sub-module sensor_debounce, parameter DB_CYC, 1-bit in/out. There are N_WIN+3 instances.
- The top level contains the FSM, hold counter, win_id priority encoder and thermal registers.

## Test plan
1. Rst, then SW=4'b0100 held 6 cycles → winbuzz=1 and win_id=2 at the 4th edge after first sample. A 3-cycle pulse on SW produces no change.
2. WIN active, SFD held → display 011→001, fdoor=1, winbuzz=0. SRD added → no change. SFD released → display 010 after DB_CYC edges.
3. SFA held 10 cycles then released, default ALARM_HOLD=16 → alarmbuzz=1 through FIRE plus exactly 16 HOLD cycles, then IDLE. Re-asserting SFA during HOLD returns display to 100.
4. ST sweep 60→45→52→56 → heater: 0, 1 at 45, stays 1 at 52, 0 at 56. ST 90→82→79 → cooler: 1, 1, 0.
5. heater=1 and SFA asserted → heater=0 in FIRE and HOLD, and 1 again one edge after leaving HOLD if ST is still < 50.
6. Rst pulsed during HOLD → all outputs 0 on that edge; display 000.
